// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage sequencer sitting upstream of data_mem.
//
// Accepts one load/store at a time from execute (valid/ready), drives the
// memory's registered control/address/write-data inputs, captures the
// synchronous read result and hands it to writeback (valid/ready).
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   req_valid      execute presents a request
//   req_ready      block can accept a request (IDLE)
//   req_is_st      1 = store, 0 = load
//   req_addr       32-bit word address
//   req_wdata      128-bit store data
//   dm_ctrl_sig    memory control: memnop / memwld / memwst
//   mem_ctrl_addr  memory address (full 32 bits; memory uses low ADDR_BITS)
//   data_in        memory write data
//   data_out       memory read data, valid the cycle after a memwld edge
//   wb_valid       load result available
//   wb_ready       writeback consumes the result
//   wb_data        load result
//   st_done        one-cycle pulse when a store has been committed
//   addr_err       sticky out-of-range flag
//
// Optional feature macro: MEM_ADDR_CHECK_EN
//   defined   -> addresses >= DEPTH are accepted but suppressed to memnop,
//                loads in error return zero, addr_err is sticky until reset
//   undefined -> no check, addr_err tied to 0
module mem_access_ctrl #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DEPTH     = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_is_st,
    input  logic [0:31]  req_addr,
    input  logic [0:127] req_wdata,
    output logic [0:1]   dm_ctrl_sig,
    output logic [0:31]  mem_ctrl_addr,
    output logic [0:127] data_in,
    input  logic [0:127] data_out,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [0:127] wb_data,
    output logic         st_done,
    output logic         addr_err
);
    localparam logic [0:1] MEMNOP = 2'b00;
    localparam logic [0:1] MEMWLD = 2'b01;
    localparam logic [0:1] MEMWST = 2'b10;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] LD_ISSUE = 3'd2;
    localparam logic [2:0] LD_CAPT  = 3'd3;
    localparam logic [2:0] LD_RESP  = 3'd4;

    // A memory larger than the address span cannot be indexed.
    if (DEPTH > (32'd1 << ADDR_BITS)) begin : g_depth_chk
        $error("mem_access_ctrl: DEPTH exceeds 2**ADDR_BITS");
    end

    logic [2:0] state;
    logic       oob;
    logic       err_q;

    assign req_ready = (state == IDLE);

`ifdef MEM_ADDR_CHECK_EN
    assign oob = (req_addr >= 32'(DEPTH));

    // err_q remembers whether the access in flight was suppressed, so the
    // load capture can return zero instead of whatever data_out holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q    <= 1'b0;
            addr_err <= 1'b0;
        end else if (req_valid && req_ready) begin
            err_q    <= oob;
            addr_err <= addr_err | oob;
        end
    end
`else
    assign oob      = 1'b0;
    assign err_q    = 1'b0;
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dm_ctrl_sig   <= MEMNOP;
            mem_ctrl_addr <= '0;
            data_in       <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            st_done       <= 1'b0;
        end else begin
            st_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_ctrl_addr <= req_addr;
                        data_in       <= req_wdata;
                        dm_ctrl_sig   <= oob ? MEMNOP : (req_is_st ? MEMWST : MEMWLD);
                        state         <= req_is_st ? ST_ISSUE : LD_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dm_ctrl_sig <= MEMNOP;
                    st_done     <= 1'b1;
                    state       <= IDLE;
                end
                LD_ISSUE: begin
                    dm_ctrl_sig <= MEMNOP;
                    state       <= LD_CAPT;
                end
                // data_out is the pre-edge read result; the memory clearing it
                // on this same memnop edge does not affect the capture.
                LD_CAPT: begin
                    wb_data  <= err_q ? '0 : data_out;
                    wb_valid <= 1'b1;
                    state    <= LD_RESP;
                end
                LD_RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer that sits directly upstream of the data memory (data_mem).
- Accepts one load or store request at a time from the execute stage using a valid/ready handshake.
- Drives the data memory's registered control, address and write-data inputs, then captures the synchronous read result.
- Returns load data to writeback using a valid/ready handshake.

Parameters:
- ADDR_BITS, 8, number of low address bits that index the 256-entry memory.
- DEPTH, 256, number of memory words; used by the optional range check.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  execute stage presents a request.
- req_ready  output  1  block accepts a request this cycle.
- req_is_st  input  1  1 = store, 0 = load.
- req_addr  input  [0:31]  word address.
- req_wdata  input  [0:127]  store data.
- dm_ctrl_sig  output  [0:1]  data memory control; uses the control.h codes memnop, memwld and memwst.
- mem_ctrl_addr  output  [0:31]  data memory address.
- data_in  output  [0:127]  data memory write data.
- data_out  input  [0:127]  data memory read data, valid the cycle after a memwld edge.
- wb_valid  output  1  load result available.
- wb_ready  input  1  writeback consumes the result.
- wb_data  output  [0:127]  load result.
- st_done  output  1  one-cycle pulse when a store has been committed.
- addr_err  output  1  sticky range-error flag (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous) forces the following, and aborts any operation in flight with no memory write:
  - state = IDLE
  - dm_ctrl_sig = memnop
  - mem_ctrl_addr = 0, data_in = 0
  - wb_valid = 0, wb_data = 0
  - st_done = 0, addr_err = 0
- All outputs are registered. req_ready = (state == IDLE) and is driven combinationally from the state register.
- IDLE:
  - On req_valid && req_ready: latch addr and wdata into mem_ctrl_addr and data_in.
  - Store: set dm_ctrl_sig = memwst, go to ST_ISSUE.
  - Load: set dm_ctrl_sig = memwld, go to LD_ISSUE.
  - With no request: dm_ctrl_sig stays memnop.
- ST_ISSUE (1 cycle): the memory writes on this edge. dm_ctrl_sig <= memnop, st_done <= 1 for one cycle, go to IDLE.
  - Store throughput: one store every 2 cycles.
- LD_ISSUE (1 cycle): the memory reads on this edge. dm_ctrl_sig <= memnop, go to LD_CAPT.
- LD_CAPT (1 cycle): on this edge, wb_data <= data_out and wb_valid <= 1, go to LD_RESP.
  - data_out is sampled as the pre-edge value; the memory clearing data_out on the same memnop edge is harmless.
- LD_RESP: hold wb_valid and wb_data stable until wb_ready is high.
  - On wb_valid && wb_ready: wb_valid <= 0, go to IDLE.
  - If wb_ready is already high on the first LD_RESP cycle, the minimum load latency is 3 edges from acceptance to wb_valid, plus a 1-cycle handshake.
- No new request is accepted while a load result is pending (no overlap).
- Address handling: mem_ctrl_addr carries the full 32-bit req_addr; the memory uses only the low ADDR_BITS. Addresses 255 and 0 wrap with no special handling.
- Back-to-back store then load to the same address: the load returns the new data, because the write edge precedes the read edge.
- req_valid deasserted before acceptance: no action. Requests are not required to be held, but the block only samples them in IDLE.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - A request with req_addr >= DEPTH is still accepted, but dm_ctrl_sig stays memnop for the access, so no write and no read occur.
  - addr_err is set and stays set until reset.
  - A load in error returns wb_data = 128'd0 with normal handshake timing.
  - A store in error still pulses st_done.
- Undefined: no check is made, addr_err is tied to 0, and the upper address bits are ignored by the memory.

Test Plan:
- Reset mid-load (rst low during LD_ISSUE) -> all outputs at reset values immediately; req_ready = 1 after release; no wb_valid.
- Store addr 0x05, data 0xDEADBEEF repeated ×4 -> dm_ctrl_sig = memwst for exactly 1 cycle, mem_ctrl_addr = 5, st_done pulses 1 cycle later, req_ready low for 1 cycle.
- Load addr 0x05 after that store, wb_ready = 1 -> wb_valid 3 edges after acceptance with wb_data = 0xDEADBEEF ×4, then req_ready = 1.
- Load with wb_ready held low 5 cycles -> wb_valid and wb_data stable all 5 cycles; req_ready = 0 throughout; completes on the first wb_ready = 1.
- Alternating store/load to addresses 0x00 and 0xFF, 20 iterations with random data -> every load matches the last store to that address; dm_ctrl_sig never shows two consecutive non-memnop cycles.
- MEM_ADDR_CHECK_EN: store to 0x100 -> dm_ctrl_sig stays memnop, addr_err = 1 and sticky, word 0x00 unchanged on readback; load from 0x100 -> wb_data = 0.
